config_write_arbiter: RTL



---
 rtl/config_write_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/config_write_arbiter.sv
// config_write_arbiter: per-source word FIFOs (USB, JTAG) feeding the eFPGA
// configuration port. One source owns the port at a time; words from the
// owner go out as single-cycle strobes spaced by at least STROBE_GAP idle
// cycles. Ownership is dropped after RELEASE_TIMEOUT empty cycles.
// Optional macro CFG_ARB_PREEMPT_EN: a pending JTAG word preempts USB ownership.
module config_write_arbiter #(
  parameter int FIFO_DEPTH      = 4,
  parameter int STROBE_GAP      = 2,
  parameter int RELEASE_TIMEOUT = 16
) (
  input  logic        clk_system_i,
  input  logic        reset_i,
  input  logic [31:0] usb_write_data_i,
  input  logic        usb_write_strobe_i,
  input  logic [31:0] jtag_write_data_i,
  input  logic        jtag_write_strobe_i,
  input  logic        jtag_active_i,
  output logic [31:0] efpga_write_data_o,
  output logic        efpga_write_strobe_o,
  output logic [1:0]  owner_o,
  output logic [1:0]  overflow_o,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(RELEASE_TIMEOUT + 1);

  // Encoding doubles as the owner_o code.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    OWN_USB  = 2'b01,
    OWN_JTAG = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [TW-1:0]   r_timeout;
  logic [TW-1:0]   w_timeout_next;
  logic [3:0]      r_gap;
  logic [31:0]     r_data;
  logic            r_strobe;
  logic [1:0]      r_overflow;

  // Index 0 = USB, index 1 = JTAG.
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_empty;
  logic [1:0]       w_drop;
  logic [1:0][31:0] w_wdata;
  logic [1:0][31:0] w_rdata;
  logic             w_emit;
  logic             w_owner_empty;
  logic             w_owner_push;

  // JTAG words only count while the TAP is active.
  assign w_push  = {jtag_write_strobe_i & jtag_active_i, usb_write_strobe_i};
  assign w_wdata = {jtag_write_data_i, usb_write_data_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [31:0] r_mem [FIFO_DEPTH];
      logic [AW:0] r_wr_ptr;
      logic [AW:0] r_rd_ptr;
      logic        w_full;
      logic        w_accept;

      assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
      assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      // A full FIFO still takes a word if it frees a slot in the same cycle.
      assign w_accept    = w_push[gi] && (!w_full || w_pop[gi]);
      assign w_drop[gi]  = w_push[gi] && w_full && !w_pop[gi];
      assign w_rdata[gi] = r_mem[r_rd_ptr[AW-1:0]];

      // Read/write pointers with wrap bit; reset flushes the FIFO.
      always_ff @(posedge clk_system_i) begin
        if (reset_i) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else begin
          if (w_accept) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
          if (w_pop[gi]) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
      end

      // Storage array; contents are don't-care once pointers are reset.
      always_ff @(posedge clk_system_i) begin
        if (w_accept) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata[gi];
      end
    end
  endgenerate

  assign w_owner_empty = (r_state == OWN_JTAG) ? w_empty[1] : w_empty[0];
  assign w_owner_push  = (r_state == OWN_JTAG) ? w_push[1]  : w_push[0];

  // Emission only from a granted state, so a grant costs one extra cycle.
  assign w_emit   = (r_state != IDLE) && !w_owner_empty && (r_gap == 4'd0);
  assign w_pop[0] = w_emit && (r_state == OWN_USB);
  assign w_pop[1] = w_emit && (r_state == OWN_JTAG);

  // State and release-timeout registers.
  always_ff @(posedge clk_system_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_timeout <= '0;
    end else begin
      r_state   <= w_state_next;
      r_timeout <= w_timeout_next;
    end
  end

  // Grant in IDLE (JTAG first); release after a full run of empty cycles.
  always_comb begin
    w_state_next   = r_state;
    w_timeout_next = r_timeout;
    case (r_state)
      IDLE: begin
        w_timeout_next = '0;
        if (!w_empty[1])      w_state_next = OWN_JTAG;
        else if (!w_empty[0]) w_state_next = OWN_USB;
      end
      OWN_USB, OWN_JTAG: begin
        if (w_owner_push || !w_owner_empty) begin
          w_timeout_next = '0;
        end else if (r_timeout == TW'(RELEASE_TIMEOUT - 1)) begin
          w_state_next   = IDLE;
          w_timeout_next = '0;
        end else begin
          w_timeout_next = r_timeout + {{(TW-1){1'b0}}, 1'b1};
        end
`ifdef CFG_ARB_PREEMPT_EN
        // A word popped this cycle still goes out; USB words left behind
        // stay queued until JTAG lets go.
        if ((r_state == OWN_USB) && !w_empty[1] && jtag_active_i) begin
          w_state_next   = OWN_JTAG;
          w_timeout_next = '0;
        end
`endif
      end
      default: begin
        w_state_next   = IDLE;
        w_timeout_next = '0;
      end
    endcase
  end

  // Gap counter: loaded on each pop, counts down to zero.
  always_ff @(posedge clk_system_i) begin
    if (reset_i)             r_gap <= 4'd0;
    else if (w_emit)         r_gap <= 4'(STROBE_GAP);
    else if (r_gap != 4'd0)  r_gap <= r_gap - 4'd1;
  end

  // Output word register (holds between strobes) and one-cycle strobe.
  always_ff @(posedge clk_system_i) begin
    if (reset_i) begin
      r_data   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_emit;
      if (w_emit) r_data <= (r_state == OWN_JTAG) ? w_rdata[1] : w_rdata[0];
    end
  end

  // Sticky drop flags.
  always_ff @(posedge clk_system_i) begin
    if (reset_i) r_overflow <= 2'b00;
    else         r_overflow <= r_overflow | w_drop;
  end

  assign efpga_write_data_o   = r_data;
  assign efpga_write_strobe_o = r_strobe;
  assign owner_o              = r_state;
  assign overflow_o           = r_overflow;
  assign busy_o               = (~w_empty != 2'b00) || (r_state != IDLE);

endmodule
